// File: rtl/load_store_unit_if.sv
// Request, RAM and writeback signals of the load/store unit.
// The master side is the controller together with the data RAM.
interface load_store_unit_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic              is_load;
  logic              is_byte;
  logic [31:0]       addr;
  logic [31:0]       st_data;
  logic [3:0]        rd;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic              ram_wr_en;
  logic [31:0]       ram_wr_data;
  logic [31:0]       ram_rd_data;
  logic [31:0]       w_data3;
  logic [3:0]        w_addr3;
  logic              w_en3;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, is_load, is_byte, addr, st_data, rd, ram_rd_data,
    input  ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    input  w_data3, w_addr3, w_en3, busy, done, err
  );

  modport slave (
    input  start, is_load, is_byte, addr, st_data, rd, ram_rd_data,
    output ram_addr, ram_rd_en, ram_wr_en, ram_wr_data,
    output w_data3, w_addr3, w_en3, busy, done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: LDR/STR/LDRB/STRB against a single-port synchronous RAM.
// Byte stores use read-modify-write; loads return through register-file write port 3.
module load_store_unit #(
  parameter int ADDR_W  = 11,
  parameter int RAM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave lsu
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_LD_WB, S_ST_WR, S_RMW_WAIT, S_RMW_WR, S_FINISH
  } state_t;

  localparam logic [2:0] LAST_WAIT = 3'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic        byte_q, byte_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  waddr_q, waddr_d;

  logic [7:0]  rd_byte;
  logic [31:0] ld_data;
  logic [31:0] merged;
  logic        misaligned;
  logic        rd_en, wr_en, wen3, done;
  logic [31:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      cnt_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    rd_byte = lsu.ram_rd_data[{addr_q[1:0], 3'b000} +: 8];
    ld_data = byte_q ? {24'h0, rd_byte} : lsu.ram_rd_data;
    merged  = lsu.ram_rd_data;
    merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    misaligned = !byte_q && (addr_q[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    load_d  = load_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    wen3    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lsu.start) begin
          addr_d = lsu.addr;
          data_d = lsu.st_data;
          rd_d   = lsu.rd;
          load_d = lsu.is_load;
          byte_d = lsu.is_byte;
          cnt_d  = '0;
          if (!lsu.is_byte && (lsu.addr[1:0] != 2'b00)) state_d = S_FINISH;
          else if (lsu.is_load)                         state_d = S_RD_WAIT;
          else if (lsu.is_byte)                         state_d = S_RMW_WAIT;
          else                                          state_d = S_ST_WR;
        end
      end
      // Loads and the read half of a byte store share the same latency wait.
      S_RD_WAIT, S_RMW_WAIT: begin
        rd_en = (cnt_q == '0);
        if (cnt_q == LAST_WAIT) state_d = (state_q == S_RD_WAIT) ? S_LD_WB : S_RMW_WR;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      S_LD_WB: begin
        wen3    = 1'b1;
        wdata_d = ld_data;
        waddr_d = rd_q;
        state_d = S_FINISH;
      end
      S_ST_WR: begin
        wr_en   = 1'b1;
        wr_data = data_q;
        state_d = S_FINISH;
      end
      S_RMW_WR: begin
        wr_en   = 1'b1;
        wr_data = merged;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writeback outputs follow the next-state value so LD_WB shows live RAM data
  // and the registered copy holds it afterwards.
  assign lsu.w_data3     = wdata_d;
  assign lsu.w_addr3     = waddr_d;
  assign lsu.w_en3       = wen3;
  assign lsu.ram_addr    = addr_q[ADDR_W+1:2];
  assign lsu.ram_rd_en   = rd_en;
  assign lsu.ram_wr_en   = wr_en;
  assign lsu.ram_wr_data = wr_data;
  assign lsu.done        = done;
  assign lsu.err         = (state_q == S_FINISH) && misaligned;
  assign lsu.busy        = (state_q != S_IDLE) && (state_q != S_FINISH);

endmodule
